systolic_input_feeder: RTL and testbench

- Upstream stage of the PE array. Buffers activation vectors (one element per array row) and drives the west edge of every row with that row's input, valid and switch signals.
- Applies the systolic skew: row r lags row 0 by r cycles.
- Attaches the weight-switch flag to the first vector of a tile whenever a background weight load has completed, so the weight swap and the tile's first input reach each PE together.

---
 rtl/tpu_pkg.sv | 13 +
 rtl/skew_delay_line.sv | 32 +++
 rtl/systolic_input_feeder.sv | 124 ++++++++++++
 tb/tb_systolic_input_feeder.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types for the PE-array front end: default element width and the
// feeder sequencing states.
package tpu_pkg;

    localparam int TPU_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-latency register chain used to stagger one PE row behind row 0.
// DELAY=0 degenerates to a plain wire.
module skew_delay_line #(
    parameter int DELAY = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DELAY == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign q_o = d_i;
    end else begin : g_chain
        logic [DELAY-1:0][WIDTH-1:0] pipe_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pipe_q <= '0;
            end else begin
                pipe_q[0] <= d_i;
                for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign q_o = pipe_q[DELAY-1];
    end

endmodule

// File: rtl/systolic_input_feeder.sv
// West-edge feeder for the PE array: buffers activation vectors, skews them
// one cycle per row and tags the first vector of a tile with the weight switch.
module systolic_input_feeder
    import tpu_pkg::*;
#(
    parameter int ROWS       = 2,
    parameter int DATA_WIDTH = TPU_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data,
    input  logic                       in_last,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       feed_en,
    input  logic                       weights_loaded,
    output logic [ROWS*DATA_WIDTH-1:0] row_input_out,
    output logic [ROWS-1:0]            row_valid_out,
    output logic [ROWS-1:0]            row_switch_out,
    output logic                       tile_done,
    output logic                       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int EW = ROWS * DATA_WIDTH;

    // FIFO entry is {vector, last}
    logic [EW:0]     mem_q [DEPTH];
    logic [AW:0]     wr_q, rd_q;
    logic            fifo_full, fifo_empty, push, pop, first_pop;
    logic [EW:0]     head;

    feeder_state_t   state_q;
    logic [CW-1:0]   cnt_q;
    logic            sw_pending_q, sw_pending_d;

    logic [EW-1:0]   r0_data_q;
    logic            r0_valid_q, r0_sw_q;

    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push       = in_valid && !fifo_full;
    assign pop        = feed_en && !fifo_empty && (state_q != DRAIN);
    assign first_pop  = pop && (state_q == IDLE);
    assign head       = mem_q[rd_q[AW-1:0]];

    assign in_ready  = !fifo_full;
    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign tile_done = (state_q == DRAIN) && (cnt_q == '0);

    // A pulse landing on the consuming pop re-arms the flag for the next tile
    assign sw_pending_d = weights_loaded || (sw_pending_q && !first_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q[AW-1:0]] <= {in_data, in_last};
                wr_q                <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_data_q    <= '0;
            r0_valid_q   <= 1'b0;
            r0_sw_q      <= 1'b0;
            sw_pending_q <= 1'b0;
        end else begin
            r0_data_q    <= pop ? head[EW:1] : '0;
            r0_valid_q   <= pop;
            r0_sw_q      <= first_pop && sw_pending_q;
            sw_pending_q <= sw_pending_d;
        end
    end

    // DRAIN holds pops until the tile's last vector has reached row ROWS-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE, STREAM: begin
                    if (pop) begin
                        state_q <= head[0] ? DRAIN : STREAM;
                        if (head[0]) cnt_q <= CW'(ROWS - 1);
                    end
                end
                DRAIN: begin
                    if (cnt_q == '0) state_q <= IDLE;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DATA_WIDTH+1:0] row_q;

        skew_delay_line #(
            .DELAY(r),
            .WIDTH(DATA_WIDTH + 2)
        ) u_skew (
            .clk(clk),
            .rst(rst),
            .d_i({r0_sw_q, r0_valid_q, r0_data_q[r*DATA_WIDTH +: DATA_WIDTH]}),
            .q_o(row_q)
        );

        assign row_switch_out[r]                        = row_q[DATA_WIDTH+1];
        assign row_valid_out[r]                         = row_q[DATA_WIDTH];
        assign row_input_out[r*DATA_WIDTH +: DATA_WIDTH] = row_q[DATA_WIDTH-1:0];
    end

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Bench for systolic_input_feeder: queue-based reference model plus directed
// scenario checks and a randomized soak.
module tb_systolic_input_feeder;

    localparam int ROWS  = 2;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int W     = ROWS * DW;
    localparam int OW    = W + 2 * ROWS + 3;
    localparam logic [OW-1:0] RST_VAL = OW'(2);

    typedef struct packed {
        logic [W-1:0] d;
        logic         last;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic [W-1:0]    in_data = '0;
    logic            in_last = 1'b0, in_valid = 1'b0, feed_en = 1'b0, weights_loaded = 1'b0;
    logic            in_ready, tile_done, busy;
    logic [W-1:0]    row_input_out;
    logic [ROWS-1:0] row_valid_out, row_switch_out;

    systolic_input_feeder #(.ROWS(ROWS), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .feed_en(feed_en), .weights_loaded(weights_loaded),
        .row_input_out(row_input_out), .row_valid_out(row_valid_out),
        .row_switch_out(row_switch_out), .tile_done(tile_done), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [OW-1:0] dut_all;
    logic [DW-1:0] r0d, r1d;
    logic          r0v, r1v;
    assign dut_all = {row_input_out, row_valid_out, row_switch_out, tile_done, in_ready, busy};
    assign r0d = row_input_out[DW-1:0];
    assign r1d = row_input_out[2*DW-1:DW];
    assign r0v = row_valid_out[0];
    assign r1v = row_valid_out[1];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    ent_t src[$];

    // ---------------- reference model ----------------
    ent_t          mq[$];
    int            drain_left = 0;
    bit            in_tile = 0, sw_pend = 0;
    logic [W-1:0]  hvec [ROWS];
    bit            hv [ROWS];
    bit            hs [ROWS];
    logic [OW-1:0] exp_all = RST_VAL;

    always @(posedge clk or posedge rst) begin : mdl
        bit do_pop, do_push, first, sw;
        ent_t e;
        logic [W-1:0] ed;
        logic [ROWS-1:0] ev, es;
        if (rst) begin
            mq.delete();
            drain_left = 0; in_tile = 0; sw_pend = 0;
            for (int r = 0; r < ROWS; r++) begin hvec[r] = '0; hv[r] = 0; hs[r] = 0; end
        end else begin
            do_push = in_valid && (mq.size() < DEPTH);
            do_pop  = feed_en && (mq.size() > 0) && (drain_left == 0);
            if (drain_left > 0) drain_left--;
            for (int r = ROWS - 1; r > 0; r--) begin
                hvec[r] = hvec[r-1]; hv[r] = hv[r-1]; hs[r] = hs[r-1];
            end
            hvec[0] = '0; hv[0] = 0; hs[0] = 0;
            first   = do_pop && !in_tile;
            sw      = first && sw_pend;
            sw_pend = weights_loaded || (sw_pend && !first);
            if (do_pop) begin
                e = mq.pop_front();
                hvec[0] = e.d; hv[0] = 1; hs[0] = sw;
                if (e.last) begin drain_left = ROWS; in_tile = 0; end
                else in_tile = 1;
            end
            if (do_push) mq.push_back({in_data, in_last});
        end
        for (int r = 0; r < ROWS; r++) begin
            ed[r*DW +: DW] = hvec[r][r*DW +: DW];
            ev[r] = hv[r];
            es[r] = hs[r];
        end
        exp_all = {ed, ev, es, drain_left == 1, mq.size() < DEPTH,
                   in_tile || (drain_left > 0) || (mq.size() > 0)};
    end

    // ---------------- stimulus ----------------
    function automatic ent_t mk(input int a, input int b, input bit l);
        ent_t e;
        e.d    = {16'(b), 16'(a)};
        e.last = l;
        return e;
    endfunction

    task automatic cycle(input bit fe, input bit wl);
        bit acc;
        in_valid = (src.size() > 0);
        in_data  = in_valid ? src[0].d : '0;
        in_last  = in_valid ? src[0].last : 1'b0;
        feed_en  = fe;
        weights_loaded = wl;
        acc = in_valid && in_ready;
        @(negedge clk);
        if (acc) src.delete(0);
        cyc++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (dut_all !== RST_VAL) begin
            n_err++; $display("FAIL reset_state got=%h exp=%h", dut_all, RST_VAL);
        end
        rst = 1'b0;
        cycle(0, 0);
        n_cmp++;
        if (dut_all !== RST_VAL || exp_all !== RST_VAL) begin
            n_err++; $display("FAIL idle_after_reset got=%h exp=%h", dut_all, RST_VAL);
        end
    endtask

    task automatic test_basic();
        src.push_back(mk(1, 2, 0));
        src.push_back(mk(3, 4, 1));
        for (int k = 1; k <= 7; k++) begin
            cycle(1, 0);
            n_cmp++;
            if (dut_all !== exp_all) begin
                n_err++; $display("FAIL basic_model cyc=%0d got=%h exp=%h", cyc, dut_all, exp_all);
            end
            n_cmp++;
            if (k == 2 && {r0v, r0d, row_switch_out, tile_done} !== {1'b1, 16'd1, 2'b00, 1'b0}) begin
                n_err++; $display("FAIL basic_row0_first got=%b/%0d exp=1/1", r0v, r0d);
            end else if (k == 3 && {r0v, r0d, r1v, r1d, tile_done} !== {1'b1, 16'd3, 1'b1, 16'd2, 1'b0}) begin
                n_err++; $display("FAIL basic_k3 got=%0d,%0d exp=3,2", r0d, r1d);
            end else if (k == 4 && {r1v, r1d, row_switch_out, tile_done} !== {1'b1, 16'd4, 2'b00, 1'b1}) begin
                n_err++; $display("FAIL basic_done got=%b/%0d/%b exp=1/4/1", r1v, r1d, tile_done);
            end else if (k > 4 && tile_done !== 1'b0) begin
                n_err++; $display("FAIL basic_extra_done got=%b exp=0", tile_done);
            end
        end
    endtask

    task automatic test_switch();
        cycle(1, 1);
        src.push_back(mk(5, 6, 1));
        for (int k = 1; k <= 6; k++) begin
            cycle(1, 0);
            n_cmp++;
            if (dut_all !== exp_all) begin
                n_err++; $display("FAIL switch_model cyc=%0d got=%h exp=%h", cyc, dut_all, exp_all);
            end
            if (k == 2) begin
                n_cmp++;
                if ({r0v, r0d, row_switch_out[0]} !== {1'b1, 16'd5, 1'b1}) begin
                    n_err++; $display("FAIL switch_row0 got=%b/%0d/%b exp=1/5/1", r0v, r0d, row_switch_out[0]);
                end
            end else if (k == 3) begin
                n_cmp++;
                if ({r1v, r1d, row_switch_out} !== {1'b1, 16'd6, 2'b10}) begin
                    n_err++; $display("FAIL switch_row1 got=%b/%0d/%b exp=1/6/10", r1v, r1d, row_switch_out);
                end
            end
        end
        src.push_back(mk(9, 10, 1));
        for (int k = 1; k <= 6; k++) begin
            cycle(1, 0);
            n_cmp++;
            if (dut_all !== exp_all || (k == 2 && {r0v, row_switch_out[0]} !== 2'b10)) begin
                n_err++; $display("FAIL switch_cleared cyc=%0d got=%h exp=%h", cyc, dut_all, exp_all);
            end
        end
    endtask

    task automatic test_full();
        logic [DW-1:0] got[$];
        bit ok;
        for (int k = 1; k <= 5; k++) src.push_back(mk(k, 100 + k, k == 5));
        for (int k = 1; k <= 6; k++) begin
            cycle(0, 0);
            n_cmp++;
            if (dut_all !== exp_all) begin
                n_err++; $display("FAIL full_model cyc=%0d got=%h exp=%h", cyc, dut_all, exp_all);
            end
            if (k == 3 || k == 4 || k == 6) begin
                n_cmp++;
                if ({in_ready, 3'(src.size())} !== ((k == 3) ? {1'b1, 3'd2} : {1'b0, 3'd1})) begin
                    n_err++; $display("FAIL full_ready k=%0d got=%b/%0d", k, in_ready, src.size());
                end
            end
        end
        cycle(1, 0);
        n_cmp++;
        if ({in_ready, r0v, r0d} !== {1'b1, 1'b1, 16'd1}) begin
            n_err++; $display("FAIL full_ready_after_pop got=%b/%b/%0d exp=1/1/1", in_ready, r0v, r0d);
        end
        got.push_back(r0d);
        for (int k = 0; k < 14; k++) begin
            cycle(1, 0);
            n_cmp++;
            if (dut_all !== exp_all) begin
                n_err++; $display("FAIL full_drain_model cyc=%0d got=%h exp=%h", cyc, dut_all, exp_all);
            end
            if (r0v) got.push_back(r0d);
        end
        ok = (got.size() == 5);
        for (int i = 0; i < got.size() && ok; i++) ok = (got[i] === 16'(i + 1));
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL full_order got_count=%0d exp=5 in order 1..5", got.size());
        end
    endtask

    task automatic test_bubbles();
        int f0 = -1, l0 = -1, f1 = -1, l1 = -1, dn = -1, nv = 0;
        for (int k = 1; k <= 4; k++) src.push_back(mk(20 + k, 40 + k, k == 4));
        for (int i = 0; i < 14; i++) begin
            cycle(!(i == 2 || i == 3), 0);
            n_cmp++;
            if (dut_all !== exp_all) begin
                n_err++; $display("FAIL bubble_model cyc=%0d got=%h exp=%h", cyc, dut_all, exp_all);
            end
            if (r0v) begin if (f0 < 0) f0 = i; l0 = i; nv++; end
            if (r1v) begin if (f1 < 0) f1 = i; l1 = i; end
            if (tile_done && dn < 0) dn = i;
        end
        n_cmp++;
        if (l0 - f0 != 5 || nv != 4 || f1 != f0 + 1 || l1 != l0 + 1) begin
            n_err++; $display("FAIL bubble_span got=%0d..%0d/%0d..%0d n=%0d exp span 5, n 4, row1 +1", f0, l0, f1, l1, nv);
        end
        n_cmp++;
        if (dn - f0 != 6) begin
            n_err++; $display("FAIL bubble_done_delay got=%0d exp=6", dn - f0);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        for (int i = 0; i < 3; i++) src.push_back(mk(11 + i, 51 + i, 0));
        while (!r1v && k < 10) begin
            cycle(1, 0);
            k++;
        end
        n_cmp++;
        if (r1v !== 1'b1) begin
            n_err++; $display("FAIL reset_mid_setup got=%b exp=1", r1v);
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (dut_all !== RST_VAL || exp_all !== RST_VAL) begin
            n_err++; $display("FAIL reset_mid_async got=%h exp=%h", dut_all, RST_VAL);
        end
        src.delete();
        @(negedge clk);
        rst = 1'b0;
        test_basic();
    endtask

    task automatic test_signed_b2b();
        int vidx[$];
        logic [DW-1:0] d0[$], d1[$];
        int dones = 0;
        src.push_back(mk(-32768, 32767, 1));
        src.push_back(mk(-1, -2, 1));
        src.push_back(mk(7, 8, 1));
        for (int k = 1; k <= 18; k++) begin
            cycle(1, 0);
            n_cmp++;
            if (dut_all !== exp_all) begin
                n_err++; $display("FAIL signed_model cyc=%0d got=%h exp=%h", cyc, dut_all, exp_all);
            end
            if (r0v) begin vidx.push_back(k); d0.push_back(r0d); end
            if (r1v) d1.push_back(r1d);
            if (tile_done) dones++;
        end
        n_cmp++;
        if (d0.size() != 3 || d1.size() != 3 ||
            {d0[0], d0[1], d0[2]} !== {16'h8000, 16'hffff, 16'h0007} ||
            {d1[0], d1[1], d1[2]} !== {16'h7fff, 16'hfffe, 16'h0008}) begin
            n_err++; $display("FAIL signed_values rows0=%0d rows1=%0d exp 3 bit-exact each", d0.size(), d1.size());
        end
        n_cmp++;
        if (dones != 3 || vidx.size() != 3 || vidx[1] - vidx[0] != 3 || vidx[2] - vidx[1] != 3) begin
            n_err++; $display("FAIL b2b_timing dones=%0d exp=3, gaps exp 3", dones);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 420; k++) begin
            if (k < 400 && src.size() < 3 && $urandom_range(1, 0) == 1)
                src.push_back(mk($urandom_range(65535), $urandom_range(65535), $urandom_range(2) == 0));
            if (k == 400 && src.size() > 0) src[src.size() - 1].last = 1'b1;
            cycle((k >= 400) || ($urandom_range(3) != 0), $urandom_range(7) == 0);
            n_cmp++;
            if (dut_all !== exp_all) begin
                n_err++; $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, dut_all, exp_all);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_basic();
        test_switch();
        test_full();
        test_bubbles();
        test_reset_mid();
        test_signed_b2b();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
